nios_system_mem_loader: RTL
===========================

// Module: nios_system_mem_loader
// PURPOSE
//  Avalon-MM master that boots the on-chip program memory: packs an 8-bit byte stream into 32-bit
//  little-endian words and writes them to consecutive word addresses, holding the CPU off the memory.
//  Sits between a host byte source (UART/JTAG bridge) and the program-memory s2 slave port.
//  It drives that slave's reset_req through cpu_hold. It reports a 32-bit additive checksum.
// PARAMETERS
//  ADDR_W      15  word-address width (32768 x 32-bit words)
//  DATA_W      32  memory word width; fixed at 32, 4 bytes per word
//  READ_LAT    1   fixed slave read latency in clk cycles (verify path only)
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   synchronous active-low reset
//  start          in   1   1-cycle pulse; begins a load when idle
//  base_addr      in   15  first word address
//  word_count     in   16  words to load, 1..32768; 0 = complete immediately, no bus traffic
//  s_data         in   8   byte stream data
//  s_valid        in   1   byte valid
//  s_ready        out  1   byte accepted when s_valid & s_ready
//  m_address      out  15  word address to memory
//  m_byteenable   out  4   always 4'hF
//  m_chipselect   out  1   asserted with m_write / m_read
//  m_write        out  1   write request
//  m_read         out  1   read request (verify only)
//  m_writedata    out  32  packed word
//  m_readdata     in   32  read data, valid READ_LAT cycles after accepted read
//  m_waitrequest  in   1   stall; hold all m_* stable while high
//  cpu_hold       out  1   to slave reset_req; high from start accept to done
//  busy           out  1   load in progress
//  done           out  1   1-cycle pulse at completion
//  error          out  1   sticky until next start; verify mismatch
//  checksum       out  32  sum mod 2^32 of written words
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, checksum 0, byte counter 0. Reset mid-load aborts at once.
//  Partial word is discarded. cpu_hold drops in the same cycle.
//  FSM: IDLE -start-> COLLECT -4th byte-> WRITE -accepted, words left-> COLLECT.
//  From WRITE, last word -> DONE (or VRD with verify). DONE -> IDLE after 1 cycle (done=1).
//  start while busy: ignored. Start is accepted in IDLE only; base_addr and word_count are latched then.
//  COLLECT: s_ready=1. Byte k (0..3) goes to writedata[8k+7:8k]. s_ready=0 in every other state.
//  WRITE: m_write=m_chipselect=1 until the first cycle with m_waitrequest=0. Then checksum += word.
//  Address then increments mod 2^15: base 0x7FFF, count 2 writes 0x7FFF then 0x0000.
//  Latency: min 5 cycles per word (4 byte accepts + 1 write), no waitrequest.
//  s_valid gaps only stall COLLECT. There is no timeout.
//  busy=1 and cpu_hold=1 in all states except IDLE. done asserts with busy still 1, then both fall next cycle.
// CONFIGURATION
//  LOADER_VERIFY_EN defined: after the last write, VRD re-reads base..base+count-1. One read is outstanding;
//  the word is captured READ_LAT cycles after acceptance. The verify sum is compared to checksum.
//  Mismatch sets error at done. Without it, no VRD state; m_read is tied 0 and error is tied 0.
// STRUCTURE
//  Package nios_system_mem_loader_pkg: state enum (IDLE, COLLECT, WRITE, VRD, VWAIT, DONE).
//  It also holds the ADDR_W/DATA_W constants and BYTES_PER_WORD=4.
//  Sub-module nios_system_byte_packer: byte valid/ready -> 32-bit word + word_valid.
//  The packer has a flush port driven by reset/abort.
// TESTING
//  base 0x0010, count 2, bytes 01..08 -> writes 0x04030201@0x10, 0x08070605@0x11; checksum 0x0C0A0806; done.
//  m_waitrequest high 3 cycles on first write -> m_address/m_writedata stable 4 cycles; single write.
//  base 0x7FFF, count 2 -> addresses 0x7FFF then 0x0000; start during load ignored; count 0 -> done next cycle.
//  reset_n low after 6 bytes -> all outputs 0 next cycle; new load starts with a clean packer.
//  VERIFY_EN: readback equal -> error=0. Memory model corrupts one word -> error=1 at done, cleared by next start.

Source files
------------

// File: rtl/nios_system_mem_loader_pkg.sv
// rtl/nios_system_mem_loader_pkg.sv - shared widths and FSM state encodings for the program-memory loader
package nios_system_mem_loader_pkg;

    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_COLLECT = 3'd1;
    localparam state_t ST_WRITE   = 3'd2;
    localparam state_t ST_VRD     = 3'd3;
    localparam state_t ST_VWAIT   = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/nios_system_mem_loader_if.sv
// rtl/nios_system_mem_loader_if.sv - byte stream and Avalon-MM program-memory port bundle
interface nios_system_mem_loader_if;
    import nios_system_mem_loader_pkg::*;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;

    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic              m_read;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest;

    modport master (
        input  s_data, s_valid, m_readdata, m_waitrequest,
        output s_ready, m_address, m_byteenable, m_chipselect, m_write, m_read, m_writedata
    );

    modport slave (
        output s_data, s_valid, m_readdata, m_waitrequest,
        input  s_ready, m_address, m_byteenable, m_chipselect, m_write, m_read, m_writedata
    );

endinterface

// File: rtl/nios_system_byte_packer.sv
// rtl/nios_system_byte_packer.sv - packs little-endian bytes into 32-bit words; flush drops any partial word
module nios_system_byte_packer
    import nios_system_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              enable_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              accept;

    assign s_ready_o    = enable_i;
    assign accept       = enable_i & s_valid_i;
    // Pulses on the edge that stores the last byte; word_o is complete the cycle after.
    assign word_valid_o = accept & (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = word_q;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (flush_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (accept) begin
            word_d[{idx_q, 3'b000} +: 8] = s_data_i;
            idx_d                        = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/nios_system_mem_loader.sv
// rtl/nios_system_mem_loader.sv - boots program memory from a byte stream; LOADER_VERIFY_EN adds readback check
module nios_system_mem_loader
    import nios_system_mem_loader_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [15:0]              word_count,
    nios_system_mem_loader_if.master bus,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_W-1:0]        checksum
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rem_q, rem_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [DATA_W-1:0] word;
    logic              word_valid;
    logic              flush;
    logic              collect;

`ifdef LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       count_q, count_d;
    logic [DATA_W-1:0] vsum_q, vsum_d, vsum_nx;
    logic [7:0]        lat_q, lat_d;
    logic              error_q, error_d;

    assign vsum_nx = vsum_q + bus.m_readdata;
`endif

    // Holding the packer flushed while idle guarantees every load starts on byte 0.
    assign flush   = (state_q == ST_IDLE);
    assign collect = (state_q == ST_COLLECT);

    nios_system_byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush),
        .enable_i     (collect),
        .s_data_i     (bus.s_data),
        .s_valid_i    (bus.s_valid),
        .s_ready_o    (bus.s_ready),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        checksum_d = checksum_q;
`ifdef LOADER_VERIFY_EN
        base_d     = base_q;
        count_d    = count_q;
        vsum_d     = vsum_q;
        lat_d      = lat_q;
        error_d    = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    rem_d      = word_count;
                    checksum_d = '0;
`ifdef LOADER_VERIFY_EN
                    base_d     = base_addr;
                    count_d    = word_count;
                    vsum_d     = '0;
                    error_d    = 1'b0;
`endif
                    state_d    = (word_count == 16'd0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!bus.m_waitrequest) begin
                    checksum_d = checksum_q + word;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
`ifdef LOADER_VERIFY_EN
                        addr_d  = base_q;
                        rem_d   = count_q;
                        state_d = ST_VRD;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            ST_VRD: begin
                if (!bus.m_waitrequest) begin
                    lat_d   = 8'(READ_LAT - 1);
                    state_d = ST_VWAIT;
                end
            end
            ST_VWAIT: begin
                if (lat_q == 8'd0) begin
                    vsum_d = vsum_nx;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        error_d = (vsum_nx != checksum_q);
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_VRD;
                    end
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            checksum_q <= checksum_d;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q  <= '0;
            count_q <= '0;
            vsum_q  <= '0;
            lat_q   <= '0;
            error_q <= 1'b0;
        end else begin
            base_q  <= base_d;
            count_q <= count_d;
            vsum_q  <= vsum_d;
            lat_q   <= lat_d;
            error_q <= error_d;
        end
    end

    assign bus.m_read = (state_q == ST_VRD);
    assign error      = error_q;
`else
    logic unused_verify;
    assign unused_verify = ^{bus.m_readdata, READ_LAT};

    assign bus.m_read = 1'b0;
    assign error      = 1'b0;
`endif

    assign bus.m_write        = (state_q == ST_WRITE);
    assign bus.m_chipselect   = bus.m_write | bus.m_read;
    assign bus.m_byteenable   = 4'hF;
    assign bus.m_address      = addr_q;
    assign bus.m_writedata    = word;

    assign busy     = (state_q != ST_IDLE);
    assign cpu_hold = busy;
    assign done     = (state_q == ST_DONE);
    assign checksum = checksum_q;

endmodule
